// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and default sizing for the iterative multiply/divide unit.
package muldiv_pkg;
    localparam int WIDTH = 16;
    localparam int ITER  = 16;
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add for multiply or restoring-subtract for divide.
module muldiv_step #(
    parameter int W = 16
) (
    input  logic         is_div,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] m,
    output logic [W-1:0] hi_n,
    output logic [W-1:0] lo_n
);
    logic [W:0]   sum;
    logic [W:0]   sh;
    logic [W-1:0] dif;
    logic         ge;
    // Remainder stays below the divisor, so the subtraction result fits W bits when ge holds.
    always_comb begin
        sum  = {1'b0, hi} + {1'b0, lo[0] ? m : {W{1'b0}}};
        sh   = {hi, lo[W-1]};
        ge   = sh >= {1'b0, m};
        dif  = sh[W-1:0] - m;
        hi_n = is_div ? (ge ? dif : sh[W-1:0]) : sum[W:1];
        lo_n = is_div ? {lo[W-2:0], ge} : {sum[0], lo[W-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide with register-file write-back strobes.
module muldiv_unit #(
    parameter int WIDTH = muldiv_pkg::WIDTH,
    parameter int ITER  = muldiv_pkg::ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       dest1,
    input  logic [3:0]       dest2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] WriteData1,
    output logic [WIDTH-1:0] WriteData2,
    output logic [3:0]       WriteReg1,
    output logic [3:0]       WriteReg2,
    output logic             RegWrite,
    output logic             WriteOP2,
    output logic             dbz
);
    import muldiv_pkg::*;
    state_t             state_q;
    logic [4:0]         cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q, m_q, hi_n, lo_n;
    logic [3:0]         d1_q, d2_q, wr1_q, wr2_q;
    logic [WIDTH-1:0]   wd1_q, wd2_q, res_lo, res_hi, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic               busy_q, done_q, dbz_q, sgn, is_div, dz;
    muldiv_step #(.W(WIDTH)) u_step (
        .is_div(op_q[1]), .hi(hi_q), .lo(lo_q), .m(m_q), .hi_n(hi_n), .lo_n(lo_n)
    );
    // Datapath runs on magnitudes; signs come back from the latched raw operands.
    always_comb begin
        sgn    = ~op_q[0];
        is_div = op_q[1];
        dz     = is_div && (b_q == '0);
        prod   = (sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo    = (sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -lo_q : lo_q;
        rem    = (sgn && a_q[WIDTH-1]) ? -hi_q : hi_q;
        res_lo = !is_div ? prod[WIDTH-1:0] : dz ? '1 : quo;
        res_hi = !is_div ? prod[2*WIDTH-1:WIDTH] : dz ? a_q : rem;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            wd1_q   <= '0;
            wd2_q   <= '0;
            wr1_q   <= '0;
            wr2_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start && !flush) begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                    op_q    <= op;
                    a_q     <= a;
                    b_q     <= b;
                    d1_q    <= dest1;
                    d2_q    <= dest2;
                    hi_q    <= '0;
                    lo_q    <= (!op[0] && a[WIDTH-1]) ? -a : a;
                    m_q     <= (!op[0] && b[WIDTH-1]) ? -b : b;
                end
                S_RUN: if (flush) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(ITER - 1)) state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    if (!flush) begin
                        done_q <= 1'b1;
                        wd1_q  <= res_lo;
                        wd2_q  <= res_hi;
                        dbz_q  <= dz;
                        wr1_q  <= d1_q;
                        wr2_q  <= d2_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign busy       = busy_q;
    assign done       = done_q;
    assign RegWrite   = done_q;
    assign WriteOP2   = done_q;
    assign dbz        = dbz_q;
    assign WriteData1 = wd1_q;
    assign WriteData2 = wd2_q;
    assign WriteReg1  = wr1_q;
    assign WriteReg2  = wr2_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width.
REQ-002 The block SHALL have parameter ITER, default 16, giving the number of iteration cycles.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  2  operation: 00 MUL signed, 01 MUL unsigned, 10 DIV signed, 11 DIV unsigned.
REQ-007 a, b  input  16 each  operands: multiplicand/multiplier, or dividend/divisor.
REQ-008 dest1, dest2  input  4 each  destination register numbers.
REQ-009 flush  input  1  abort any operation in progress.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle pulse; result outputs are valid while it is high.
REQ-012 WriteData1, WriteData2  output  16 each  low product/quotient, and high product/remainder.
REQ-013 WriteReg1, WriteReg2  output  4 each  dest1/dest2 as captured at start.
REQ-014 RegWrite, WriteOP2  output  1 each  register-file write strobes; equal to done.
REQ-015 dbz  output  1  divide-by-zero flag; valid with done.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 In IDLE with start=1 and flush=0, the block SHALL latch op, a, b, dest1 and dest2, then enter RUN.
REQ-018 The block SHALL stay in RUN for exactly ITER cycles, performing one radix-2 shift-add or restoring-subtract step per cycle, counted by a 5-bit counter.
REQ-019 After the last RUN cycle the block SHALL enter DONE for exactly one cycle and then return to IDLE.
REQ-020 done SHALL rise exactly ITER+1 cycles after the edge that accepted start.
REQ-021 Back-to-back operations SHALL be possible: start sampled in the cycle after DONE is accepted.
REQ-022 start SHALL be ignored while busy=1, with no queueing.
REQ-023 Signed operations SHALL compute on magnitudes and sign-correct the result in the DONE transition.
REQ-024 MUL SHALL produce the full 32-bit product: WriteData1 = bits 15:0, WriteData2 = bits 31:16.
REQ-025 DIV SHALL truncate toward zero: WriteData1 = quotient, WriteData2 = remainder, remainder sign equal to the dividend sign.
REQ-026 DIV with b=0 SHALL give quotient 0xFFFF, remainder = a and dbz=1, and still take the full ITER+1 latency.
REQ-027 Signed DIV of 0x8000 by 0xFFFF SHALL give quotient 0x8000, remainder 0x0000 and dbz=0.
REQ-028 flush=1 in RUN or DONE SHALL force IDLE on the next edge with done, RegWrite and WriteOP2 low that cycle, so no register write occurs.
REQ-029 When flush and start are both high in IDLE, flush SHALL win and the start SHALL be dropped.
REQ-030 All outputs SHALL be registered; WriteData*, WriteReg* and dbz SHALL hold their last values outside done.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, clear the counter, and zero busy, done, RegWrite, WriteOP2, dbz, WriteData1, WriteData2, WriteReg1 and WriteReg2.
REQ-032 Reset mid-operation SHALL abandon the operation without any done pulse.
REQ-033 rst SHALL take priority over flush and start.

Structure
REQ-034 A shared package muldiv_pkg SHALL hold the op encodings (OP_MUL, OP_MULU, OP_DIV, OP_DIVU), the state encoding, WIDTH and ITER.
REQ-035 One combinational sub-module, muldiv_step, SHALL perform a single radix-2 step (partial product/remainder update) and be instantiated once.
REQ-036 Control, counter and sign correction SHALL stay in muldiv_unit.

Verification
REQ-037 op=01, a=0x0E12, b=0x0045 -> after 17 cycles done=1, WriteData1=0xCADA, WriteData2=0x0003, RegWrite=WriteOP2=1.
REQ-038 op=00, a=0xF08F, b=0x0002 -> WriteData1=0xE11E, WriteData2=0xFFFF.
REQ-039 op=11, a=0x6789, b=0x00EB -> quotient 0x0070, remainder 0x00B9; op=10, a=0xFF56, b=0x0007 -> quotient 0xFFE8, remainder 0xFFFE.
REQ-040 op=10, a=0x0045, b=0x0000 -> quotient 0xFFFF, remainder 0x0045, dbz=1; op=10, a=0x8000, b=0xFFFF -> quotient 0x8000, remainder 0x0000.
REQ-041 start pulsed while busy is ignored; flush at RUN cycle 8 -> IDLE next cycle with no done; rst at RUN cycle 5 -> all outputs zero and no done.
REQ-042 Two operations issued back-to-back -> done pulses exactly 18 cycles apart with correct WriteReg1/WriteReg2 for each.
